// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared data width and requester ID constants for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int size_X_LEN = 32;

  localparam logic ARB_ID_IF = 1'b0;
  localparam logic ARB_ID_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory request/response bundle
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic                  if_req_i, if_we_i;
  logic [size_X_LEN-1:0] if_addr_i, if_wdata_i;
  logic [3:0]            if_be_i;
  logic                  if_gnt_o, if_rvalid_o;
  logic [size_X_LEN-1:0] if_rdata_o;

  logic                  ls_req_i, ls_we_i;
  logic [size_X_LEN-1:0] ls_addr_i, ls_wdata_i;
  logic [3:0]            ls_be_i;
  logic                  ls_gnt_o, ls_rvalid_o;
  logic [size_X_LEN-1:0] ls_rdata_o;

  logic                  mem_req_o, mem_we_o;
  logic [size_X_LEN-1:0] mem_addr_o, mem_wdata_o;
  logic [3:0]            mem_be_o;
  logic                  mem_gnt_i, mem_rvalid_i;
  logic [size_X_LEN-1:0] mem_rdata_i;

  modport master (
    input  if_req_i, if_we_i, if_addr_i, if_wdata_i, if_be_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    output if_req_i, if_we_i, if_addr_i, if_wdata_i, if_be_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_id_fifo.sv
// rtl/mem_port_arbiter_id_fifo.sv - in-order 1-bit requester ID FIFO tracking outstanding memory requests
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  // When full, a simultaneous pop frees the head slot that the push overwrites.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = din_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) rptr_d = ptr_inc(rptr_q);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, routing responses by ID
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise load/store has fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_FIFO_AW      = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                err_o
);

  logic any_req, sel, can_issue, handshake, pop;
  logic id_head, id_full, id_empty;
  logic err_q, err_d;

  assign any_req = bus.if_req_i | bus.ls_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    sel = bus.ls_req_i ? ARB_ID_LS : ARB_ID_IF;
    if (bus.if_req_i && bus.ls_req_i) sel = ~last_grant_q;
  end

  assign last_grant_d = handshake ? sel : last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= ARB_ID_LS;
    else       last_grant_q <= last_grant_d;
  end
`else
  assign sel = bus.ls_req_i ? ARB_ID_LS : ARB_ID_IF;
`endif

  // A response in this cycle frees a slot, so a full tracker can still issue.
  assign can_issue     = ~id_full | bus.mem_rvalid_i;
  assign bus.mem_req_o = any_req & can_issue & ~reset;
  assign handshake     = bus.mem_req_o & bus.mem_gnt_i;
  assign bus.if_gnt_o  = handshake & (sel == ARB_ID_IF);
  assign bus.ls_gnt_o  = handshake & (sel == ARB_ID_LS);

  always_comb begin
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    if (any_req) begin
      if (sel == ARB_ID_LS) begin
        bus.mem_we_o    = bus.ls_we_i;
        bus.mem_addr_o  = bus.ls_addr_i;
        bus.mem_wdata_o = bus.ls_wdata_i;
        bus.mem_be_o    = bus.ls_be_i;
      end else begin
        bus.mem_we_o    = bus.if_we_i;
        bus.mem_addr_o  = bus.if_addr_i;
        bus.mem_wdata_o = bus.if_wdata_i;
        bus.mem_be_o    = bus.if_be_i;
      end
    end
  end

  assign pop             = bus.mem_rvalid_i & ~id_empty & ~reset;
  assign bus.if_rvalid_o = pop & (id_head == ARB_ID_IF);
  assign bus.ls_rvalid_o = pop & (id_head == ARB_ID_LS);
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.ls_rdata_o  = bus.mem_rdata_i;

  assign err_d = err_q | (bus.mem_rvalid_i & id_empty);
  assign err_o = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .AW    (ID_FIFO_AW)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (handshake),
    .pop_i   (pop),
    .din_i   (sel),
    .head_o  (id_head),
    .full_o  (id_full),
    .empty_o (id_empty)
  );

endmodule
